// File: rtl/nes_video_pkg.sv
// Shared NES video constants, the RGB pixel type and the 2C02 palette.
// Each palette colour is stored as 8-bit RGB and widened to 10 bits by replicating the top bits.
package nes_video_pkg;

    localparam int unsigned NES_PAL_W   = 6;
    localparam int unsigned RGB_W       = 10;
    localparam int unsigned SRC_W       = 256;
    localparam int unsigned PAL_ENTRIES = 64;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    localparam logic [23:0] NES_PALETTE_888 [PAL_ENTRIES] = '{
        24'h545454, 24'h001E74, 24'h081090, 24'h300088,
        24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
        24'h202A00, 24'h083A00, 24'h004000, 24'h003C00,
        24'h00323C, 24'h000000, 24'h000000, 24'h000000,
        24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4,
        24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
        24'h545A00, 24'h287200, 24'h087C00, 24'h007628,
        24'h006678, 24'h000000, 24'h000000, 24'h000000,
        24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC,
        24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
        24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C,
        24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
        24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC,
        24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
        24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4,
        24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
    };

    function automatic logic [RGB_W-1:0] expand8(input logic [7:0] v);
        return {v, v[7:6]};
    endfunction

    function automatic rgb_t palette_lookup(input logic [NES_PAL_W-1:0] idx);
        logic [23:0] c;
        rgb_t        o;
        c   = NES_PALETTE_888[idx];
        o.r = expand8(c[23:16]);
        o.g = expand8(c[15:8]);
        o.b = expand8(c[7:0]);
        return o;
    endfunction

endpackage

// File: rtl/nes_palette_rom.sv
// Registered NES palette lookup: 6-bit index in, 30-bit RGB out one clock later.
// Blanked indices (idx_valid_i low) produce black.
module nes_palette_rom
    import nes_video_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 idx_valid_i,
    input  logic [NES_PAL_W-1:0] idx_i,
    output rgb_t                 rgb_o
);

    rgb_t rgb_q;
    rgb_t rgb_d;

    always_comb begin
        rgb_d = '0;
        if (idx_valid_i) begin
            rgb_d = palette_lookup(idx_i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/nes_line_doubler.sv
// Ping-pong line buffer between the NES PPU and the VGA timing block: stores 256-pixel
// source lines and replays them 2x scaled and horizontally centred, with 2-clock read latency.
module nes_line_doubler
    import nes_video_pkg::NES_PAL_W, nes_video_pkg::RGB_W, nes_video_pkg::rgb_t;
#(
    parameter int unsigned SRC_W       = nes_video_pkg::SRC_W,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned H_OFFSET    = 64,
    parameter int unsigned V_LINES     = 480
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pix_line_start,
    input  logic                 pix_valid,
    input  logic [NES_PAL_W-1:0] pix_data,
    input  logic [9:0]           x_addr,
    input  logic [9:0]           y_addr,
    output logic [RGB_W-1:0]     vga_r,
    output logic [RGB_W-1:0]     vga_g,
    output logic [RGB_W-1:0]     vga_b,
    output logic                 line_req,
    output logic                 overflow
);

    localparam int unsigned ADDR_W = $clog2(SRC_W);
    // One extra bit so the pointer can sit at SRC_W instead of wrapping.
    localparam int unsigned PTR_W  = ADDR_W + 1;

    localparam logic [9:0]       X_START  = 10'(H_OFFSET);
    localparam logic [9:0]       X_END    = 10'(H_OFFSET + (SRC_W << SCALE_SHIFT));
    localparam logic [9:0]       Y_END    = 10'(V_LINES);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(SRC_W);

    // Both line buffers share one RAM; the top address bit selects the buffer.
    logic [NES_PAL_W-1:0] line_mem [2*SRC_W];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic             overflow_q, overflow_d;
    logic             mem_we;
    logic [ADDR_W:0]  mem_waddr;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = {wr_sel_q, wr_ptr_q[ADDR_W-1:0]};
        if (pix_line_start) begin
            rd_sel_d = wr_sel_q;
            wr_sel_d = ~wr_sel_q;
            wr_ptr_d = '0;
            if (pix_valid) begin
                mem_we    = 1'b1;
                mem_waddr = {~wr_sel_q, ADDR_W'(0)};
                wr_ptr_d  = PTR_W'(1);
            end
        end else if (pix_valid) begin
            if (wr_ptr_q < PTR_FULL) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            line_mem[mem_waddr] <= pix_data;
        end
    end

    // Stage 1: window test and buffer read.
    logic [9:0]           x_rel;
    logic [ADDR_W-1:0]    src_x;
    logic                 in_win_d, in_win_q;
    logic [NES_PAL_W-1:0] idx_d, idx_q;

    always_comb begin
        x_rel    = x_addr - X_START;
        src_x    = ADDR_W'(x_rel >> SCALE_SHIFT);
        in_win_d = (x_addr >= X_START) && (x_addr < X_END) && (y_addr < Y_END);
        idx_d    = line_mem[{rd_sel_q, src_x}];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            in_win_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            in_win_q <= in_win_d;
        end
    end

    // Stage 2: palette conversion.
    rgb_t rgb;

    nes_palette_rom u_palette_rom (
        .clock       (clock),
        .reset       (reset),
        .idx_valid_i (in_win_q),
        .idx_i       (idx_q),
        .rgb_o       (rgb)
    );

    // A falling edge of y bit 0 marks the first display row of each source-line pair.
    logic y0_q, y0_d;
    logic line_req_q, line_req_d;

    always_comb begin
        y0_d       = y_addr[0];
        line_req_d = y0_q && !y_addr[0] && (y_addr < Y_END);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y0_q       <= 1'b0;
            line_req_q <= 1'b0;
        end else begin
            y0_q       <= y0_d;
            line_req_q <= line_req_d;
        end
    end

    assign vga_r    = rgb.r;
    assign vga_g    = rgb.g;
    assign vga_b    = rgb.b;
    assign line_req = line_req_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nes_line_doubler.sv
// Self-checking bench for nes_line_doubler: directed stimulus with a scoreboard of
// expected RGB values popped by a monitor as each probed address leaves the pipeline.
module tb_nes_line_doubler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pix_line_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [5:0] pix_data = '0;
    logic [9:0] x_addr = '0;
    logic [9:0] y_addr = '0;
    logic [9:0] vga_r, vga_g, vga_b;
    logic       line_req, overflow;

    nes_line_doubler dut (
        .clock          (clock),
        .reset          (reset),
        .pix_line_start (pix_line_start),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .x_addr         (x_addr),
        .y_addr         (y_addr),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .line_req       (line_req),
        .overflow       (overflow)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic [29:0] rgb;
        int          id;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t sb_q[$];
    chk_t chk_q[$];
    exp_t mon_e;
    chk_t mon_c;
    int   checks = 0;
    int   errors = 0;
    int   lr_cnt = 0;
    int   probe_id = 0;
    logic probe = 1'b0;
    logic done = 1'b0;
    logic [1:0] probe_pipe = '0;

    // Hand-converted palette entries used by the directed vectors.
    function automatic logic [29:0] pal(input int idx);
        case (idx)
            8'h00:   return {10'h151, 10'h151, 10'h151};
            8'h01:   return {10'h000, 10'h078, 10'h1D1};
            8'h02:   return {10'h020, 10'h040, 10'h242};
            8'h15:   return {10'h282, 10'h050, 10'h191};
            8'h2A:   return {10'h131, 10'h343, 10'h080};
            default: return 30'h0;
        endcase
    endfunction

    // Monitor: sole owner of the check/error counters.
    always @(negedge clock) begin
        while (chk_q.size() != 0) begin
            mon_c = chk_q.pop_front();
            checks++;
            if (mon_c.act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_c.name, mon_c.act, mon_c.exp);
            end
        end
        if (reset) begin
            probe_pipe = '0;
        end else begin
            if (probe_pipe[1]) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rgb_underflow: output with no expected entry");
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({vga_r, vga_g, vga_b} !== mon_e.rgb) begin
                        errors++;
                        $display("FAIL rgb_probe%0d: got 0x%0h, expected 0x%0h",
                                 mon_e.id, {vga_r, vga_g, vga_b}, mon_e.rgb);
                    end
                end
            end
            probe_pipe = {probe_pipe[0], probe};
            if (line_req) lr_cnt++;
        end
        if (done) begin
            if (sb_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL rgb_drain: %0d expected outputs never arrived", sb_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic do_probe(input int x, input int y, input logic [29:0] exp);
        exp_t e;
        x_addr = 10'(x);
        y_addr = 10'(y);
        probe  = 1'b1;
        e.rgb  = exp;
        e.id   = probe_id++;
        sb_q.push_back(e);
        tick();
        probe = 1'b0;
    endtask

    task automatic line_start();
        pix_line_start = 1'b1;
        tick();
        pix_line_start = 1'b0;
    endtask

    task automatic fill(input int n, input logic [5:0] d);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = d;
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    initial begin
        int base;
        #1 reset = 1'b1;
        #2;
        chk("rst0_vga_r", 32'(vga_r), 0);
        chk("rst0_vga_g", 32'(vga_g), 0);
        chk("rst0_vga_b", 32'(vga_b), 0);
        chk("rst0_line_req", 32'(line_req), 0);
        chk("rst0_overflow", 32'(overflow), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Ramp 0..63 four times, then display it.
        line_start();
        for (int i = 0; i < 256; i++) begin
            pix_valid = 1'b1;
            pix_data  = 6'(i % 64);
            tick();
        end
        pix_valid = 1'b0;
        line_start();
        do_probe(64, 0, pal(0));
        do_probe(65, 0, pal(0));
        do_probe(66, 0, pal(1));
        do_probe(68, 0, pal(2));
        do_probe(195, 0, pal(1));
        do_probe(63, 0, 30'h0);
        do_probe(576, 0, 30'h0);
        do_probe(100, 480, 30'h0);
        x_addr = '0;
        y_addr = '0;
        settle();

        // line_req edges.
        y_addr = 10'd1;
        settle();
        base = lr_cnt;
        y_addr = 10'd2;
        settle();
        chk("line_req_1to2", 32'(lr_cnt - base), 1);
        base = lr_cnt;
        y_addr = 10'd3;
        settle();
        chk("line_req_2to3", 32'(lr_cnt - base), 0);
        y_addr = 10'd479;
        settle();
        base = lr_cnt;
        y_addr = 10'd0;
        settle();
        chk("line_req_479to0", 32'(lr_cnt - base), 1);
        y_addr = 10'd481;
        settle();
        base = lr_cnt;
        y_addr = 10'd482;
        settle();
        chk("line_req_blank", 32'(lr_cnt - base), 0);
        y_addr = 10'd0;
        settle();

        // Overflow: 257 pixels into one line.
        line_start();
        for (int i = 1; i <= 257; i++) begin
            pix_valid = 1'b1;
            pix_data  = (i == 256) ? 6'h15 : (i == 257) ? 6'h3F : 6'(i % 64);
            tick();
            if (i == 256) chk("overflow_after_256", 32'(overflow), 0);
        end
        pix_valid = 1'b0;
        chk("overflow_after_257", 32'(overflow), 1);
        line_start();
        do_probe(574, 0, pal(8'h15));
        do_probe(64, 0, pal(1));
        settle();

        // Line start and pixel in the same cycle.
        pix_line_start = 1'b1;
        pix_valid      = 1'b1;
        pix_data       = 6'h2A;
        tick();
        pix_line_start = 1'b0;
        pix_valid      = 1'b0;
        line_start();
        do_probe(64, 0, pal(8'h2A));
        settle();

        // Back-to-back lines A then B.
        line_start();
        fill(256, 6'h01);
        line_start();
        do_probe(64, 0, pal(1));
        do_probe(300, 0, pal(1));
        fill(256, 6'h02);
        do_probe(64, 0, pal(1));
        line_start();
        do_probe(64, 0, pal(2));
        do_probe(300, 0, pal(2));
        settle();

        // Asynchronous reset with outputs active.
        x_addr = 10'd64;
        y_addr = 10'd1;
        settle();
        chk("pre_reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'(pal(2)));
        y_addr = 10'd2;
        tick();
        chk("pre_reset_line_req", 32'(line_req), 1);
        #3 reset = 1'b1;
        #1;
        chk("rst1_vga_r", 32'(vga_r), 0);
        chk("rst1_vga_g", 32'(vga_g), 0);
        chk("rst1_vga_b", 32'(vga_b), 0);
        chk("rst1_line_req", 32'(line_req), 0);
        chk("rst1_overflow", 32'(overflow), 0);
        tick();
        reset  = 1'b0;
        x_addr = '0;
        y_addr = '0;
        tick();

        // Short line after reset still swaps in cleanly.
        line_start();
        fill(4, 6'h01);
        line_start();
        do_probe(64, 0, pal(1));
        do_probe(66, 0, pal(1));
        settle();
        chk("overflow_post_reset", 32'(overflow), 0);

        repeat (5) tick();
        done = 1'b1;
    end

endmodule
